// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction and data requesters; data has priority, bounded by a starve limit.
// Per-access timeout sets a sticky err and returns the request to arbitration.
module mem_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              err
);

  localparam int SCNT_W = $clog2(STARVE_LIM) + 1;
  localparam int TCNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t            r_state;
  logic [SCNT_W-1:0] r_scnt;
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_err;

  logic w_dreq, w_iacc, w_dacc, w_iown, w_down, w_idone, w_ddone, w_starve, w_tmo;

  // Reset forces the IDLE output equations even while the state register still holds an access state.
  assign w_dreq   = dREN | dWEN;
  assign w_iacc   = !RST && (r_state == IACC);
  assign w_dacc   = !RST && (r_state == DACC);
  assign w_iown   = w_iacc && iREN;
  assign w_down   = w_dacc && w_dreq;
  assign w_idone  = w_iown && ram_ready;
  assign w_ddone  = w_down && ram_ready;
  assign w_starve = (r_scnt == SCNT_W'(STARVE_LIM)) && iREN;
  assign w_tmo    = (r_tcnt == TCNT_W'(TIMEOUT - 1));

  assign ramREN   = w_iown || (w_down && !dWEN);
  assign ramWEN   = w_down && dWEN;
  assign ramaddr  = w_iown ? iaddr : (w_down ? daddr : '0);
  assign ramstore = w_down ? dstore : '0;
  assign iwait    = w_iacc ? !w_idone : iREN;
  assign dwait    = w_dacc ? !w_ddone : w_dreq;
  assign iload    = w_idone ? ramload : '0;
  assign dload    = w_ddone ? ramload : '0;
  assign err      = r_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_scnt  <= '0;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tcnt <= '0;
          if (w_starve) begin
            r_state <= IACC;
            r_scnt  <= '0;
          end else if (w_dreq) begin
            r_state <= DACC;
            r_scnt  <= iREN ? r_scnt + 1'b1 : '0;
          end else begin
            r_state <= iREN ? IACC : IDLE;
            r_scnt  <= '0;
          end
        end
        IACC: begin
          if (!iREN || ram_ready) begin
            r_state <= IDLE;
          end else if (w_tmo) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else begin
            r_tcnt  <= r_tcnt + 1'b1;
          end
        end
        DACC: begin
          if (!w_dreq || ram_ready) begin
            r_state <= IDLE;
          end else if (w_tmo) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else begin
            r_tcnt  <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1ns after each rising edge, outputs checked 1ns later.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [1:0] starve_exp [12];

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 32'hDEADBEEF;

    // reset state and IDLE equations during reset
    tick; tick;
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
    check("rst_waits_idle", {30'b0, iwait, dwait}, 32'd0);
    iREN = 1; dWEN = 1; #1;
    check("rst_waits_req", {30'b0, iwait, dwait}, 32'd3);
    check("rst_wen_low", {31'b0, ramWEN}, 32'd0);
    tick;
    iREN = 0; dWEN = 0; RST = 0;
    tick;

    // single instruction read
    iREN = 1; iaddr = 32'h40; #1;
    check("i_idle_wait", {30'b0, iwait, ramREN}, 32'd2);
    tick;
    ram_ready = 1; #1;
    check("i_acc_ren", {31'b0, ramREN}, 32'd1);
    check("i_acc_addr", ramaddr, 32'h40);
    check("i_acc_iwait", {31'b0, iwait}, 32'd0);
    check("i_acc_iload", iload, 32'hDEADBEEF);
    check("i_acc_dload0", dload, 32'd0);
    tick;
    iREN = 0; ram_ready = 0; #1;
    check("i_back_idle", {31'b0, ramREN}, 32'd0);
    check("i_iload_zero", iload, 32'd0);
    tick;

    // simultaneous requests: data first, IDLE, then instruction
    iREN = 1; dREN = 1; daddr = 32'h84; ram_ready = 1; ramload = 32'h0BADF00D; #1;
    check("both_idle", {29'b0, iwait, dwait, ramREN}, 32'd6);
    tick;
    check("both_c1_waits", {30'b0, iwait, dwait}, 32'd2);
    check("both_c1_dload", dload, 32'h0BADF00D);
    check("both_c1_addr", ramaddr, 32'h84);
    tick;
    dREN = 0; #1;
    check("both_c2_idle", {31'b0, ramREN}, 32'd0);
    tick;
    check("both_c3_iwait", {30'b0, iwait, dwait}, 32'd0);
    check("both_c3_iload", iload, 32'h0BADF00D);
    tick;
    iREN = 0; ram_ready = 0;
    tick;

    // starvation: four data grants, then one instruction, then data again
    starve_exp = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10,
                   2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10};
    iREN = 1; dREN = 1; ram_ready = 1;
    for (int c = 0; c < 12; c++) begin
      #1;
      check($sformatf("starve_c%0d", c), {30'b0, iwait, dwait}, {30'b0, starve_exp[c]});
      tick;
    end
    iREN = 0; dREN = 0; ram_ready = 0;
    tick;

    // write wins over read; then data abort
    dREN = 1; dWEN = 1; dstore = 32'h1234; daddr = 32'h80; #1;
    check("wr_idle", {30'b0, ramREN, ramWEN}, 32'd0);
    tick;
    check("wr_strobes", {30'b0, ramREN, ramWEN}, 32'd1);
    check("wr_store", ramstore, 32'h1234);
    check("wr_addr", ramaddr, 32'h80);
    check("wr_dwait", {31'b0, dwait}, 32'd1);
    tick;
    dREN = 0; dWEN = 0; ram_ready = 1; #1;
    check("dab_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
    check("dab_nodone", {31'b0, dwait}, 32'd1);
    check("dab_dload", dload, 32'd0);
    tick;
    dREN = 1; #1;
    check("dab_idle", {31'b0, ramREN}, 32'd0);
    tick;
    check("rd_after_ab", {30'b0, ramREN, dwait}, 32'd2);
    check("rd_after_dload", dload, 32'h0BADF00D);
    tick;
    dREN = 0; ram_ready = 0;
    tick;

    // reset pulsed mid-instruction access
    iREN = 1; iaddr = 32'h44;
    tick;
    check("irst_acc", {31'b0, ramREN}, 32'd1);
    tick;
    RST = 1; ram_ready = 1; #1;
    check("irst_strobe", {31'b0, ramREN}, 32'd0);
    check("irst_nodone", {31'b0, iwait}, 32'd1);
    check("irst_iload", iload, 32'd0);
    tick;
    RST = 0; #1;
    check("irst_idle", {30'b0, ramREN, iwait}, 32'd1);
    tick;
    check("irst_retry", {31'b0, iwait}, 32'd0);
    tick;
    iREN = 0; ram_ready = 0;
    tick;

    // timeout: 64 stalled IACC cycles, err, back to IDLE, re-enter IACC
    iREN = 1; iaddr = 32'h48;
    tick;
    for (int c = 1; c < 64; c++) tick;
    check("tmo_last_acc", {30'b0, ramREN, err}, 32'd2);
    tick;
    check("tmo_idle_err", {29'b0, ramREN, iwait, err}, 32'd3);
    tick;
    check("tmo_reacc", {30'b0, ramREN, err}, 32'd3);
    ram_ready = 1; #1;
    check("tmo_done", {31'b0, iwait}, 32'd0);
    tick;
    iREN = 0; ram_ready = 0;
    tick; tick;
    check("err_sticky", {31'b0, err}, 32'd1);
    RST = 1;
    tick;
    check("err_cleared", {31'b0, err}, 32'd0);
    RST = 0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning data/address width.
REQ-002 SHALL have parameter STARVE_LIM, default 4, meaning the count of consecutive data grants after which a pending instruction request is granted next.
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning the maximum cycles in an access state without ram_ready.
REQ-004 CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 iREN  in  1  instruction read request, held until served.
REQ-007 iaddr  in  WORD_W  instruction address.
REQ-008 iwait  out  1  instruction stall; low only in the instruction completion cycle.
REQ-009 iload  out  WORD_W  instruction read data, valid while iwait=0 and iREN=1.
REQ-010 dREN, dWEN  in  1 each  data read and write requests, held until served.
REQ-011 daddr, dstore  in  WORD_W each  data address and write data.
REQ-012 dwait  out  1  data stall; low only in the data completion cycle.
REQ-013 dload  out  WORD_W  data read data, valid while dwait=0 and dREN=1.
REQ-014 ramREN, ramWEN  out  1 each  RAM read and write strobes.
REQ-015 ramaddr, ramstore  out  WORD_W each  RAM address and write data.
REQ-016 ramload  in  WORD_W  RAM read data.
REQ-017 ram_ready  in  1  RAM access complete this cycle.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 The arbiter SHALL be an FSM with states IDLE, IACC, DACC; only IDLE arbitrates.
REQ-020 In IDLE, ramREN and ramWEN SHALL be 0, and iwait SHALL equal iREN and dwait SHALL equal (dREN|dWEN).
REQ-021 In IDLE, if (dREN|dWEN) and no starve override applies, the next state SHALL be DACC; otherwise, if iREN, it SHALL be IACC; otherwise it SHALL stay IDLE.
REQ-022 Starve counter scnt (width clog2(STARVE_LIM)+1): it SHALL increment on each IDLE->DACC while iREN=1, and SHALL clear on IDLE->IACC or when iREN=0 in IDLE.
REQ-023 In IDLE, when scnt==STARVE_LIM and iREN=1, the next state SHALL be IACC regardless of data requests.
REQ-024 In IACC: ramREN=1, ramWEN=0, ramaddr=iaddr, and dwait=(dREN|dWEN).
REQ-025 In DACC: ramaddr=daddr, ramstore=dstore, and iwait=iREN.
REQ-026 In DACC, if dWEN=1 then ramWEN=1 and ramREN=0 (write wins when both are set); otherwise ramREN=1 and ramWEN=0.
REQ-027 In IACC with ram_ready=1: iwait SHALL be 0, iload SHALL equal ramload (combinational), and the next state SHALL be IDLE.
REQ-028 In DACC with ram_ready=1: dwait SHALL be 0, dload SHALL equal ramload, and the next state SHALL be IDLE.
REQ-029 Minimum latency SHALL be 2 cycles from request assertion in IDLE to completion (IDLE cycle, then access cycle with ram_ready).
REQ-030 Back-to-back requests SHALL always pass through one IDLE cycle.
REQ-031 Abort: if the owning request drops in IACC/DACC (iREN=0, or dREN=dWEN=0), strobes SHALL go low that cycle, no completion SHALL be signalled, and the next state SHALL be IDLE.
REQ-032 Timeout counter tcnt SHALL clear on entry to IACC/DACC and increment each access cycle without ram_ready.
REQ-033 When tcnt reaches TIMEOUT-1 without ram_ready, err SHALL set, the FSM SHALL return to IDLE with wait held high, and the request SHALL be re-arbitrated.
REQ-034 err SHALL remain 1 until reset.
REQ-035 iload and dload SHALL be 0 when not in their completion cycle.
REQ-036 ram_ready in IDLE SHALL be ignored.

Reset
REQ-037 While RST=1 at a rising edge: state SHALL become IDLE and scnt, tcnt, and err SHALL become 0.
REQ-038 After reset, ram strobes SHALL be 0; reset mid-access SHALL abandon the access with no completion.
REQ-039 Outputs during reset SHALL follow the IDLE equations of REQ-020.

Verification
REQ-040 iREN=1, iaddr=0x40, ram_ready high the cycle after -> cycle 1 IACC with ramREN=1 and ramaddr=0x40; iwait=0 and iload=ramload (0xDEADBEEF) in that cycle.
REQ-041 iREN=1 and dREN=1 asserted together, ram_ready=1 every access cycle -> DACC first (dwait low at cycle 1), then IDLE, then IACC (iwait low at cycle 3).
REQ-042 iREN held with continuous data requests, STARVE_LIM=4 -> exactly 4 data completions, then an instruction completion, then data resumes.
REQ-043 dREN=dWEN=1, dstore=0x1234, daddr=0x80 -> ramWEN=1, ramREN=0, ramstore=0x1234, ramaddr=0x80.
REQ-044 ram_ready held 0 with TIMEOUT=64 -> after 64 cycles in IACC, err=1, FSM returns to IDLE and re-enters IACC; RST=1 clears err.
REQ-045 dREN dropped mid-DACC, and RST pulsed mid-IACC -> strobes low, no completion signalled, FSM in IDLE next cycle.
